// File: rtl/uart_pkg.sv
// Shared constants, width helper and divisor-pair type for the fractional UART baud generator.
package uart_pkg;

  localparam int unsigned UART_OVS_DEFAULT    = 16;
  localparam int unsigned UART_CNT_W_DEFAULT  = 16;
  localparam int unsigned UART_FRAC_W_DEFAULT = 3;

  // Width of the oversample phase counter; never narrower than one bit.
  function automatic int unsigned uart_ovs_width(input int unsigned ovs);
    return (ovs < 2) ? 1 : $clog2(ovs);
  endfunction

  typedef struct packed {
    logic [UART_CNT_W_DEFAULT-1:0]  baud_val;
    logic [UART_FRAC_W_DEFAULT-1:0] baud_frac;
  } uart_div_t;

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional carry accumulator: each load adds baud_frac; a carry requests one stretch cycle.
module uart_frac_acc #(
  parameter int unsigned FRAC_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              load,
  input  logic              consume,
  input  logic [FRAC_W-1:0] baud_frac,
  output logic              stretch
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, baud_frac};
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clr) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (load) begin
      {stretch_d, acc_d} = sum;
    end else if (consume) begin
      stretch_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch = stretch_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: oversample tick, bit pulse and oversample phase.
// Optional UART_BAUD_IMM_RELOAD_EN forces an immediate reload when the divisor inputs change.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W  = UART_CNT_W_DEFAULT,
  parameter int unsigned FRAC_W = UART_FRAC_W_DEFAULT,
  parameter int unsigned OVS    = UART_OVS_DEFAULT,
  parameter int unsigned OVS_W  = uart_ovs_width(OVS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  baud_val,
  input  logic [FRAC_W-1:0] baud_frac,
  output logic              baud_tick,
  output logic              xmit_pulse,
  output logic [OVS_W-1:0]  ovs_cnt
);

  localparam logic [OVS_W-1:0] OvsMax = OVS_W'(OVS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OVS_W-1:0] ovs_q, ovs_d;
  logic             tick_q, tick_d;
  logic             xmit_q, xmit_d;
  logic             stretch;
  logic             cnt_zero;
  logic             nat_load;
  logic             force_load;

  assign cnt_zero = (cnt_q == '0);
  assign nat_load = en && cnt_zero && !stretch;

`ifdef UART_BAUD_IMM_RELOAD_EN
  logic [CNT_W+FRAC_W-1:0] shadow_q, shadow_d;

  assign force_load = en && ({baud_val, baud_frac} != shadow_q);

  // Shadow follows the inputs while idle so a restart looks exactly like leaving reset.
  always_comb begin
    shadow_d = shadow_q;
    if (!en || nat_load || force_load) begin
      shadow_d = {baud_val, baud_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= {baud_val, baud_frac};
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign force_load = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    ovs_d  = ovs_q;
    tick_d = 1'b0;
    xmit_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      ovs_d = '0;
    end else if (force_load) begin
      cnt_d  = baud_val;
      ovs_d  = '0;
      tick_d = 1'b1;
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!stretch) begin
      cnt_d  = baud_val;
      tick_d = 1'b1;
      xmit_d = (ovs_q == OvsMax);
      ovs_d  = (ovs_q == OvsMax) ? '0 : ovs_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      ovs_q  <= '0;
      tick_q <= 1'b0;
      xmit_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovs_q  <= ovs_d;
      tick_q <= tick_d;
      xmit_q <= xmit_d;
    end
  end

  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (!en || force_load),
    .load      (nat_load && !force_load),
    .consume   (en && !force_load && cnt_zero && stretch),
    .baud_frac (baud_frac),
    .stretch   (stretch)
  );

  assign baud_tick  = tick_q;
  assign xmit_pulse = xmit_q;
  assign ovs_cnt    = ovs_q;

endmodule
